// File: rtl/spll_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spll_pkg
//  Description : Shared types and constants for the software PLL with lock
//                detection: lock FSM state encoding and phase-error codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package spll_pkg;

   // Lock-detector state encoding
   typedef enum logic [1:0] {
      ST_ACQUIRE  = 2'd0,
      ST_VERIFY   = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_HOLDOVER = 2'd3
   } lock_state_t;

   // Phase-detector output codes
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LAG  = 2'b01;
   localparam logic [1:0] ERR_LEAD = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spll_lock_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : spll_lock_fsm
//  Description : Input edge detector, silence counter, error-window counter
//                and the ACQUIRE/VERIFY/LOCKED/HOLDOVER lock state machine.
//                A window spans 2^LOCK_BITS samples; the sample on which the
//                window wraps is included in that window's error count.
//  Revision    : 1.0 - initial release
// ============================================================================
module spll_lock_fsm
   import spll_pkg::*;
#(
   parameter int LOCK_BITS = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 sample,
   input  logic                 phase_err,
   input  logic                 ld,
   input  logic [LOCK_BITS-1:0] lock_thresh,
   input  logic [LOCK_BITS-1:0] holdover_len,
   output logic                 locked,
   output logic                 holdover
);

   lock_state_t          state, state_nxt;
   logic                 prev_sample;
   logic [LOCK_BITS-1:0] silence, silence_nxt;
   logic [LOCK_BITS-1:0] window;
   logic [LOCK_BITS-1:0] err_cnt, err_inc;
   logic                 edge_det, wrap, good, hold_trig, hold_exit;

   assign edge_det  = (sample != prev_sample);
   assign wrap      = (window == '1);
   assign hold_exit = (state == ST_HOLDOVER) && edge_det;

   // Saturating silence and error counts as they would be after this sample
   always_comb begin
      silence_nxt = '0;
      if (!edge_det)
         silence_nxt = (silence == '1) ? silence : silence + LOCK_BITS'(1);
      err_inc = (err_cnt == '1) ? err_cnt : err_cnt + LOCK_BITS'(phase_err);
      good      = (err_inc <= lock_thresh);
      hold_trig = (holdover_len != '0) && (silence_nxt == holdover_len);
   end

   // Edge history, silence and window/error counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_sample <= 1'b0;
         silence     <= '0;
         window      <= '0;
         err_cnt     <= '0;
      end else begin
         if (ce) begin
            prev_sample <= sample;
            silence     <= silence_nxt;
         end
         if (ld) begin
            window  <= '0;
            err_cnt <= '0;
         end else if (ce) begin
            if (hold_exit) begin
               window  <= '0;
               err_cnt <= '0;
            end else begin
               window  <= window + LOCK_BITS'(1);
               err_cnt <= wrap ? '0 : err_inc;
            end
         end
      end
   end

   // Lock state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_ACQUIRE;
      else
         state <= state_nxt;
   end

   // Next state: load beats holdover entry, which beats holdover exit,
   // which beats window evaluation
   always_comb begin
      state_nxt = state;
      if (ld) begin
         state_nxt = ST_ACQUIRE;
      end else if (ce) begin
         if (hold_trig) begin
            state_nxt = ST_HOLDOVER;
         end else if (hold_exit) begin
            state_nxt = ST_VERIFY;
         end else if (wrap) begin
            case (state)
               ST_ACQUIRE: if (good) state_nxt = ST_VERIFY;
               ST_VERIFY:  state_nxt = good ? ST_LOCKED : ST_ACQUIRE;
               ST_LOCKED:  if (!good) state_nxt = ST_ACQUIRE;
               default:    state_nxt = state;
            endcase
         end
      end
   end

   assign locked   = (state == ST_LOCKED);
   assign holdover = (state == ST_HOLDOVER);

endmodule
`default_nettype wire

// File: rtl/spll_lockdet.sv
`default_nettype none
// ============================================================================
//  Module      : spll_lockdet
//  Description : NCO phase accumulator steered by a bang-bang phase detector,
//                with saturating frequency tracking, windowed lock detection
//                and holdover on loss of input edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module spll_lockdet
   import spll_pkg::*;
#(
   parameter int                    PHASE_BITS          = 32,
   parameter int                    LOCK_BITS           = 16,
   parameter bit                    OPT_TRACK_FREQUENCY = 1'b1,
   parameter bit                    OPT_GLITCHLESS      = 1'b1,
   parameter logic [PHASE_BITS-1:0] INITIAL_PHASE_STEP  = '0,
   parameter logic [PHASE_BITS-1:0] STEP_MIN            = PHASE_BITS'(1),
   parameter logic [PHASE_BITS-1:0] STEP_MAX            = {1'b0, {(PHASE_BITS-1){1'b1}}}
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_ld,
   input  logic [PHASE_BITS-2:0] i_step,
   input  logic                  i_ce,
   input  logic                  i_input,
   input  logic [4:0]            i_lgcoeff,
   input  logic [LOCK_BITS-1:0]  i_lock_thresh,
   input  logic [LOCK_BITS-1:0]  i_holdover_len,
   output logic [PHASE_BITS-1:0] o_phase,
   output logic                  o_clk,
   output logic [1:0]            o_err,
   output logic [PHASE_BITS-1:0] o_step,
   output logic                  o_locked,
   output logic                  o_holdover
);

   localparam int MSB = PHASE_BITS - 1;

   logic [PHASE_BITS-1:0] ctr, ctr_nxt;
   logic [PHASE_BITS-1:0] r_step, step_up, step_dn;
   logic [PHASE_BITS-1:0] phase_correction, freq_correction;
   logic                  agreed, phase_err, lead, holdover;
   logic [1:0]            err_nxt;

   // Clamp a widened step value into [STEP_MIN, STEP_MAX]
   function automatic logic [PHASE_BITS-1:0] clamp_step(input logic [PHASE_BITS:0] v);
      if (v < {1'b0, STEP_MIN})
         return STEP_MIN;
      else if (v > {1'b0, STEP_MAX})
         return STEP_MAX;
      else
         return v[PHASE_BITS-1:0];
   endfunction

   assign phase_err = ctr[MSB] ^ i_input;
   assign lead      = agreed ? (!ctr[MSB] && i_input) : (ctr[MSB] && !i_input);

   // Accumulator, step candidates and error code for the current sample
   always_comb begin
      ctr_nxt = ctr + r_step;
      if (!holdover && phase_err) begin
         if (lead)
            ctr_nxt = (!OPT_GLITCHLESS || (r_step > phase_correction))
                      ? ctr + r_step - phase_correction : ctr;
         else
            ctr_nxt = ctr + r_step + phase_correction;
      end
      step_up = clamp_step({1'b0, r_step} + {1'b0, freq_correction});
      step_dn = (r_step > freq_correction)
                ? clamp_step({1'b0, r_step - freq_correction}) : STEP_MIN;
      err_nxt = ERR_NONE;
      if (!holdover && phase_err)
         err_nxt = lead ? ERR_LEAD : ERR_LAG;
   end

   // Loop gains, accumulator, detector memory, step and error register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         phase_correction <= '0;
         freq_correction  <= '0;
         ctr              <= '0;
         agreed           <= 1'b0;
         o_err            <= ERR_NONE;
         r_step           <= INITIAL_PHASE_STEP;
      end else begin
         phase_correction <= {1'b1, {(PHASE_BITS-1){1'b0}}} >> i_lgcoeff;
         freq_correction  <= {3'b001, {(PHASE_BITS-3){1'b0}}} >> {i_lgcoeff, 1'b0};
         if (i_ce) begin
            ctr   <= ctr_nxt;
            o_err <= err_nxt;
            if (ctr[MSB] && i_input)
               agreed <= 1'b1;
            else if (!ctr[MSB] && !i_input)
               agreed <= 1'b0;
         end
         if (i_ld)
            r_step <= clamp_step({2'b00, i_step});
         else if (i_ce && OPT_TRACK_FREQUENCY && phase_err && !holdover)
            r_step <= lead ? step_dn : step_up;
      end
   end

   spll_lock_fsm #(
      .LOCK_BITS (LOCK_BITS)
   ) u_lock_fsm (
      .clk          (i_clk),
      .rst          (i_reset),
      .ce           (i_ce),
      .sample       (i_input),
      .phase_err    (phase_err),
      .ld           (i_ld),
      .lock_thresh  (i_lock_thresh),
      .holdover_len (i_holdover_len),
      .locked       (o_locked),
      .holdover     (holdover)
   );

   assign o_phase    = ctr;
   assign o_clk      = ctr[MSB];
   assign o_step     = r_step;
   assign o_holdover = holdover;

endmodule
`default_nettype wire

// File: tb/tb_spll_lockdet.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spll_lockdet
//  Description : Directed, table-driven bench for spll_lockdet with a second
//                instance using a reduced STEP_MAX for saturation checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spll_lockdet;

   localparam int LB = 4;
   localparam logic [31:0] STEP_NOM = 32'h0800_0000;
   localparam logic [31:0] SMAX2    = 32'h0780_0000;

   logic          clk = 1'b0;
   logic          rst, ld, ce, in_bit;
   logic [30:0]   step_in;
   logic [4:0]    lgcoeff;
   logic [LB-1:0] thresh, hlen;

   logic [31:0] phase_a, step_a, phase_b, step_b;
   logic        clk_a, locked_a, hold_a, clk_b, locked_b, hold_b;
   logic [1:0]  err_a, err_b;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   spll_lockdet #(.PHASE_BITS(32), .LOCK_BITS(LB)) dut (
      .i_clk(clk), .i_reset(rst), .i_ld(ld), .i_step(step_in), .i_ce(ce),
      .i_input(in_bit), .i_lgcoeff(lgcoeff), .i_lock_thresh(thresh),
      .i_holdover_len(hlen), .o_phase(phase_a), .o_clk(clk_a), .o_err(err_a),
      .o_step(step_a), .o_locked(locked_a), .o_holdover(hold_a)
   );

   spll_lockdet #(.PHASE_BITS(32), .LOCK_BITS(LB), .STEP_MAX(SMAX2)) dut_max (
      .i_clk(clk), .i_reset(rst), .i_ld(ld), .i_step(step_in), .i_ce(ce),
      .i_input(in_bit), .i_lgcoeff(lgcoeff), .i_lock_thresh(thresh),
      .i_holdover_len(hlen), .o_phase(phase_b), .o_clk(clk_b), .o_err(err_b),
      .o_step(step_b), .o_locked(locked_b), .o_holdover(hold_b)
   );

   typedef struct {
      bit          in;
      bit [LB-1:0] hlen;
      bit [31:0]   phase;
      bit [1:0]    err;
      bit          locked;
      bit          hold;
   } vec_t;

   vec_t vecs [107];

   function automatic bit pat(int n);
      return (n % 32) >= 16;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      bit band_hit, lock_seen;
      logic [31:0] max_b;
      int over_b;

      // Square input at the NCO rate; holdover on a held-low input from
      // sample 65, first edge at sample 90 exits to VERIFY and relocks
      for (int n = 0; n < 107; n++) begin
         vecs[n].in     = (n < 64) ? pat(n) : ((n < 90) ? 1'b0 : pat(n));
         vecs[n].hlen   = (n >= 64 && n < 90) ? LB'(5) : LB'(0);
         vecs[n].phase  = 32'(n + 1) << 27;
         vecs[n].err    = 2'b00;
         vecs[n].locked = (n >= 31 && n <= 68) || (n >= 106);
         vecs[n].hold   = (n >= 69 && n <= 89);
      end

      rst = 1'b1; ld = 1'b0; ce = 1'b0; in_bit = 1'b0; step_in = '0;
      lgcoeff = 5'd4; thresh = LB'(2); hlen = '0;
      tick();
      chk("reset_phase", phase_a, 32'h0);
      chk("reset_step", step_a, 32'h0);
      chk("reset_err", 32'(err_a), 32'h0);
      chk("reset_locked", 32'(locked_a), 32'h0);
      chk("reset_hold", 32'(hold_a), 32'h0);
      rst = 1'b0;
      tick();

      ld = 1'b1; step_in = 31'(STEP_NOM);
      tick();
      ld = 1'b0;
      chk("ld_step", step_a, STEP_NOM);
      chk("ld_clamp_max", step_b, SMAX2);
      tick(); tick();
      chk("no_ce_hold", phase_a, 32'h0);

      // Table: tracking, lock after two windows, holdover, relock
      for (int n = 0; n < 107; n++) begin
         in_bit = vecs[n].in;
         hlen   = vecs[n].hlen;
         ce     = 1'b1;
         tick();
         chk($sformatf("v%0d_phase", n), phase_a, vecs[n].phase);
         chk($sformatf("v%0d_clk", n), 32'(clk_a), 32'(vecs[n].phase[31]));
         chk($sformatf("v%0d_err", n), 32'(err_a), 32'(vecs[n].err));
         chk($sformatf("v%0d_step", n), step_a, STEP_NOM);
         chk($sformatf("v%0d_locked", n), 32'(locked_a), 32'(vecs[n].locked));
         chk($sformatf("v%0d_hold", n), 32'(hold_a), 32'(vecs[n].hold));
      end

      // Too many errors in a locked window drop lock at the window end
      for (int n = 107; n < 123; n++) begin
         in_bit = (n == 108 || n == 110 || n == 112) ? 1'b1 : pat(n);
         ce = 1'b1;
         tick();
         if (n == 108) chk("inject_err_lag", 32'(err_a), 32'h1);
         if (n == 121) chk("still_locked", 32'(locked_a), 32'h1);
         if (n == 122) begin
            chk("lock_dropped", 32'(locked_a), 32'h0);
            chk("no_hold_after_drop", 32'(hold_a), 32'h0);
         end
      end
      ce = 1'b0;

      // Asynchronous reset between clock edges
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_phase", phase_a, 32'h0);
      chk("async_clk", 32'(clk_a), 32'h0);
      chk("async_step", step_a, 32'h0);
      chk("async_err", 32'(err_a), 32'h0);
      chk("async_locked", 32'(locked_a), 32'h0);
      chk("async_hold", 32'(hold_a), 32'h0);
      tick();
      rst = 1'b0;

      // Glitchless lead suppression with maximum loop gain
      lgcoeff = 5'd0;
      ld = 1'b1; step_in = 31'h200;
      tick();
      ld = 1'b1; step_in = 31'h100; ce = 1'b1; in_bit = 1'b1;
      tick();
      ld = 1'b0; ce = 1'b0;
      chk("lag_phase_old_step", phase_a, 32'h8000_0200);
      chk("lag_err", 32'(err_a), 32'h1);
      chk("ld_beats_track", step_a, 32'h100);
      ce = 1'b1; in_bit = 1'b0;
      tick();
      ce = 1'b0;
      chk("lead_ctr_holds", phase_a, 32'h8000_0200);
      chk("lead_err", 32'(err_a), 32'h3);
      chk("step_sat_min", step_a, 32'h1);

      // Frequency tracking from a slow initial step
      rst = 1'b1;
      tick();
      rst = 1'b0; lgcoeff = 5'd4; thresh = LB'(8); hlen = '0;
      ld = 1'b1; step_in = 31'h7FFF_FFFF;
      tick();
      chk("ld_full_a", step_a, 32'h7FFF_FFFF);
      chk("ld_full_b", step_b, SMAX2);
      step_in = 31'h0;
      tick();
      chk("ld_zero_clamp", step_a, 32'h1);
      step_in = 31'h0700_0000;
      tick();
      ld = 1'b0;
      chk("ld_slow", step_a, 32'h0700_0000);
      tick();
      band_hit = 1'b0; lock_seen = 1'b0; max_b = '0; over_b = 0;
      for (int n = 0; n < 3000; n++) begin
         in_bit = pat(n);
         ce = 1'b1;
         tick();
         if (step_a >= 32'h07E0_0000 && step_a <= 32'h0820_0000) band_hit = 1'b1;
         if (locked_a) lock_seen = 1'b1;
         if (step_b > max_b) max_b = step_b;
         if (step_b > SMAX2) over_b++;
      end
      ce = 1'b0;
      chk("track_band", 32'(band_hit), 32'h1);
      chk("track_locked", 32'(lock_seen), 32'h1);
      chk("sat_max_reached", max_b, SMAX2);
      chk("sat_no_overrun", 32'(over_b), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spll_lockdet.md
# spll_lockdet

Parametrised successor to the team's single-bit software PLL: an NCO phase accumulator steered by a bang-bang phase detector, with saturating frequency tracking. It adds a windowed lock detector, a loss-of-input holdover mode, and an asynchronous reset. It sits between a sampled serial/clock input and any logic needing a recovered clock, phase word or lock status.

## Interface
- PHASE_BITS, 32, accumulator width (MSB = PHASE_BITS-1)
- LOCK_BITS, 16, window/silence counter width; window = 2^LOCK_BITS i_ce samples
- OPT_TRACK_FREQUENCY, 1, enable r_step tracking
- OPT_GLITCHLESS, 1, suppress lead correction unless r_step > phase_correction
- INITIAL_PHASE_STEP, 0, reset value of r_step
- STEP_MIN, 1 / STEP_MAX, 2^(PHASE_BITS-1)-1, r_step clamp limits
- i_clk in 1, clock
- i_reset in 1, asynchronous, active-high reset
- i_ld in 1, load step; i_step in PHASE_BITS-1, new step (zero-extended)
- i_ce in 1, sample enable; i_input in 1, reference bit
- i_lgcoeff in 5, loop gain exponent
- i_lock_thresh in LOCK_BITS, max phase-error samples per good window
- i_holdover_len in LOCK_BITS, edge-free samples before holdover; 0 disables holdover
- o_phase out PHASE_BITS, accumulator; o_clk out 1, o_phase[MSB]
- o_err out 2, 00 none, 01 lag, 11 lead
- o_step out PHASE_BITS, current r_step
- o_locked out 1; o_holdover out 1

## Operation
- One clock; reset is asynchronous and active-high. Reset values: ctr=0, r_step=INITIAL_PHASE_STEP, o_err=0, corrections=0, all counters 0, state ACQUIRE, o_locked=0, o_holdover=0.
- Phase detector: phase_err = ctr[MSB]!=i_input. agreed is set when both are high and cleared when both are low, updated on i_ce. lead = agreed ? (!ctr[MSB]&&i_input) : (ctr[MSB]&&!i_input).
- phase_correction <= 2^MSB >> i_lgcoeff. freq_correction <= 2^(MSB-2) >> 2*i_lgcoeff. Both registered every clock.
- ctr update on i_ce:
  - No error, or HOLDOVER: ctr+r_step.
  - Lead: ctr+r_step-phase_correction. Under OPT_GLITCHLESS this applies only when r_step>phase_correction; otherwise ctr holds.
  - Lag: ctr+r_step+phase_correction.
  - All arithmetic is modulo 2^PHASE_BITS.
- r_step:
  - i_ld has priority and loads clamp({0,i_step}).
  - Otherwise, on i_ce with OPT_TRACK_FREQUENCY, phase_err and not HOLDOVER: r_step -/+ freq_correction (lead/lag), saturated to [STEP_MIN,STEP_MAX] with no wrap.
- o_err is registered on i_ce and forced 00 in HOLDOVER.
- Edge: i_input differs from its value at the previous i_ce sample.
- Silence counter: clears on edge, otherwise increments per i_ce and saturates at all-ones.
- Window counter: increments per i_ce. err_cnt counts phase_err samples and saturates. At window wrap, good = err_cnt<=i_lock_thresh, and err_cnt restarts.
- FSM:
  - ACQUIRE: good→VERIFY.
  - VERIFY: good→LOCKED, bad→ACQUIRE.
  - LOCKED: bad→ACQUIRE.
  - Any state: silence==i_holdover_len (nonzero) → HOLDOVER.
  - HOLDOVER: edge→VERIFY with window and err_cnt cleared.
  - i_ld in any state → ACQUIRE with window cleared.
- o_locked = state==LOCKED; o_holdover = state==HOLDOVER.

## Timing
- ctr, r_step, o_err and the FSM all update on the i_ce edge. Outputs are registered, so they change one clock after the sampled i_ce.
- i_lgcoeff change affects corrections after 1 clock.
- i_ld together with i_ce: ctr uses the old r_step; the new step applies from the next i_ce.
- Window wrap in the same cycle as the holdover trigger: holdover wins.
- Edge in HOLDOVER in the same cycle as window wrap: exit to VERIFY wins and the window restarts.
- i_ld takes priority over every FSM event.
- Reset mid-operation clears everything immediately, with no clock required.

## Structure
- spll_pkg holds the FSM state encoding (ACQUIRE=0, VERIFY=1, LOCKED=2, HOLDOVER=3) and o_err code constants.
- Sub-module spll_lock_fsm contains the edge detector, silence counter, window/err_cnt and FSM. It outputs the holdover flag to the datapath.

## Test plan
1. Run with PHASE_BITS=32, step 0x0800_0000, i_lgcoeff=4, and a square input at the same rate. After reset, o_err stays 00, o_locked rises after two windows, and o_clk tracks i_input.
2. Run with tracking on, loaded step 0x0700_0000, and input at a 0x0800_0000 rate. o_step converges to within ±freq_correction of 0x0800_0000 and o_locked is asserted. With STEP_MAX=0x0780_0000, o_step saturates at 0x0780_0000 and never wraps.
3. With LOCK_BITS=4 and i_holdover_len=5, hold i_input constant while LOCKED. o_holdover rises after the 5th edge-free i_ce, o_step is frozen, and ctr advances by exactly r_step per i_ce. The first edge enters VERIFY.
4. Force errors above i_lock_thresh=2 in a window while LOCKED. At window end o_locked drops and the state is ACQUIRE.
5. Set OPT_GLITCHLESS=1, r_step=0x100 and i_lgcoeff=0 with a lead error. ctr holds, and o_err=11.
6. Assert i_reset asynchronously mid-window. All outputs read their reset values before the next clock edge.
